lock_ctrl: RTL and testbench
============================

# lock_ctrl

Password-management controller sequencing the 4-slot password register file of the smart lock. Accepts keypad commands (verify, enroll, delete), scans all slots through the register file's read port, and drives its save/delete strobes. Produces the `unlocked` output, per-command status, and an optional failed-attempt lockout alarm. Sits between the keypad front end and the register file.

## Interface
- `UNLOCK_CYCLES`, 1000: cycles `unlocked` stays high after a successful verify.
- `MAX_FAILS`, 3: consecutive failed verifies that trigger lockout.
- `LOCKOUT_CYCLES`, 5000: lockout duration in cycles.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `code_in`  in  16  entered code; sampled with `code_valid`.
- `code_valid`  in  1  one-cycle command strobe.
- `cmd`  in  2  0 = verify, 1 = enroll, 2 = delete, 3 = reserved (ignored).
- `slot_sel`  in  2  slot to delete.
- `rf_data_out`  in  17  register file read data: bit 16 = slot valid, [15:0] = code; combinational on `rf_read_addr`.
- `rf_data_in`  out  16  write data.
- `rf_save`  out  1  one-cycle save strobe.
- `rf_save_addr`  out  2  save address.
- `rf_delete`  out  1  one-cycle delete strobe.
- `rf_del_addr`  out  2  delete address.
- `rf_read_addr`  out  2  read address.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `status`  out  3  valid with `done`: 0 OK, 1 NOMATCH, 2 FULL, 3 DUP, 4 AUTH, 5 LOCKED.
- `unlocked`  out  1  lock-open level.
- `alarm`  out  1  high during lockout.

## Operation
- States: IDLE, SCAN, SAVE, DEL, DONE, LOCKOUT.
- Reset values: all outputs 0; fail counter 0; unlock timer 0; state IDLE.
- IDLE: on `code_valid` with `cmd` ≠ 3, latch `code_in`, `cmd`, `slot_sel`, and the authorization flag `auth = unlocked`. With `busy` high, `code_valid` is ignored.
- Verify/enroll → SCAN. `rf_read_addr` walks 0..3, one slot per cycle.
  - Per slot, record `match = valid && code == latched`.
  - Record the first slot with `valid == 0` as the free slot.
  - Record `any_valid`.
- Verify after scan:
  - Any match → OK. Reload the unlock timer to `UNLOCK_CYCLES`, even if already unlocked. Clear the fail counter.
  - No match → NOMATCH. Increment the fail counter.
- Enroll after scan:
  - `!auth && any_valid` → AUTH.
  - Else match → DUP.
  - Else no free slot → FULL.
  - Else SAVE: `rf_save` = 1 for one cycle, `rf_save_addr` = first free slot, `rf_data_in` = code. Then OK.
- Delete:
  - `!auth` → AUTH; no strobe.
  - Otherwise DEL: `rf_delete` = 1 for one cycle, `rf_del_addr` = `slot_sel`. Deleting an empty slot still returns OK.
- Unlock timer: decrements independently of the FSM. `unlocked` = (timer ≠ 0). Enroll and delete do not change the timer.
- Counter widths: `$clog2(param+1)`; no wrap. The fail counter saturates at `MAX_FAILS`.

## Timing
- Command accepted at cycle T.
- SCAN runs T+1..T+4 (`rf_read_addr` = 0, 1, 2, 3).
- Verify: `done` at T+5. On OK, `unlocked` rises at T+5.
- Enroll error: `done` at T+5.
- Enroll OK: `rf_save` at T+5, `done` at T+6.
- Delete:
  - AUTH: `done` at T+1.
  - OK: `rf_delete` at T+1, `done` at T+2.
- `busy` is high from T+1 through the `done` cycle. IDLE is re-entered the cycle after `done`, so the earliest next accept is the cycle after `done`.
- `auth` is frozen at T. Unlock expiry mid-command does not abort the command.
- `reset_n` low at any point, including mid-SCAN or during a strobe:
  - All outputs drop immediately, asynchronously.
  - The FSM returns to IDLE.
  - Register file contents are not touched by this block.

## Configuration
- `LOCK_CTRL_LOCKOUT_EN` defined:
  - A NOMATCH that brings the fail counter to `MAX_FAILS` enters LOCKOUT at `done`+1, with `alarm` = 1 for `LOCKOUT_CYCLES` cycles.
  - During LOCKOUT, each `code_valid` gives a `done` pulse on the next cycle with status LOCKED; no register file access.
  - On exit: `alarm` = 0, fail counter cleared, state IDLE.
- Undefined:
  - No fail counter and no LOCKOUT state.
  - `alarm` tied to 0.
  - Status LOCKED is never produced.

## Test plan
- After reset (empty table, locked), enroll 0x1234 → `rf_save` at T+5 with addr 0, data 0x1234; `done` at T+6 with status 0.
- Verify 0x1234 → `done` at T+5, status 0. `unlocked` is high for exactly `UNLOCK_CYCLES` (set to 8 in the bench).
- While unlocked:
  - Enroll 0x1234 → DUP (3).
  - Enroll 0xAAAA, 0xBBBB, 0xCCCC → slots 1, 2, 3.
  - Enroll 0xDDDD → FULL (2), no `rf_save`.
- While locked, delete slot 1 → AUTH (4) at T+1, no `rf_delete`. After unlock, delete slot 1 → `rf_delete` with addr 1 at T+1. Then verify 0xAAAA → NOMATCH (1).
- `MAX_FAILS` = 3, `LOCKOUT_CYCLES` = 10; three wrong verifies of 0x0000:
  - Third attempt: `done` with status 1, then `alarm` = 1 on the next cycle.
  - A verify during lockout → LOCKED (5).
  - `alarm` falls after 10 cycles.
  - With the macro undefined, `alarm` stays 0.
- Pull `reset_n` low at T+2 of a verify → `busy`, `rf_*` strobes, `done`, and `unlocked` are 0 immediately. After release, a new command is accepted normally.

Source files
------------

// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lock_ctrl
// Purpose  : Password controller for the 4-slot lock register file; scans
//            slots for verify/enroll, strobes save/delete, drives unlock.
//            Optional lockout alarm: define LOCK_CTRL_LOCKOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module lock_ctrl #(
   parameter int UNLOCK_CYCLES  = 1000,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 5000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] i_code_in,
   input  logic        i_code_valid,
   input  logic [1:0]  i_cmd,
   input  logic [1:0]  i_slot_sel,
   input  logic [16:0] i_rf_data_out,
   output logic [15:0] o_rf_data_in,
   output logic        o_rf_save,
   output logic [1:0]  o_rf_save_addr,
   output logic        o_rf_delete,
   output logic [1:0]  o_rf_del_addr,
   output logic [1:0]  o_rf_read_addr,
   output logic        o_busy,
   output logic        o_done,
   output logic [2:0]  o_status,
   output logic        o_unlocked,
   output logic        o_alarm
);

   localparam logic [1:0] c_CMD_VERIFY = 2'd0;
   localparam logic [1:0] c_CMD_DELETE = 2'd2;
   localparam logic [1:0] c_CMD_RSVD   = 2'd3;

   localparam logic [2:0] c_ST_OK      = 3'd0;
   localparam logic [2:0] c_ST_NOMATCH = 3'd1;
   localparam logic [2:0] c_ST_FULL    = 3'd2;
   localparam logic [2:0] c_ST_DUP     = 3'd3;
   localparam logic [2:0] c_ST_AUTH    = 3'd4;

   localparam int c_UW = $clog2(UNLOCK_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_SAVE,
      S_DEL,
      S_DONE
`ifdef LOCK_CTRL_LOCKOUT_EN
      , S_LOCKOUT
`endif
   } state_t;

   state_t          r_state;
   logic [15:0]     r_code;
   logic [1:0]      r_cmd;
   logic            r_auth;
   logic [1:0]      r_idx;
   logic            r_match;
   logic            r_any_valid;
   logic            r_free_vld;
   logic [1:0]      r_free_addr;
   logic [c_UW-1:0] r_unlock_tmr;

   logic            w_slot_valid;
   logic            w_slot_match;
   logic            w_match;
   logic            w_any_valid;
   logic            w_free_vld;
   logic [1:0]      w_free_addr;
   logic            w_scan_last;
   logic            w_verify_ok;
   logic            w_verify_fail;

   // Scan results fold in the slot currently on the read port, so the last
   // slot is decided in the same cycle it is read.
   assign w_slot_valid   = i_rf_data_out[16];
   assign w_slot_match   = w_slot_valid && (i_rf_data_out[15:0] == r_code);
   assign w_match        = r_match | w_slot_match;
   assign w_any_valid    = r_any_valid | w_slot_valid;
   assign w_free_vld     = r_free_vld | ~w_slot_valid;
   assign w_free_addr    = r_free_vld ? r_free_addr : r_idx;
   assign w_scan_last    = (r_state == S_SCAN) && (r_idx == 2'd3);
   assign w_verify_ok    = w_scan_last && (r_cmd == c_CMD_VERIFY) && w_match;
   assign w_verify_fail  = w_scan_last && (r_cmd == c_CMD_VERIFY) && !w_match;
   assign o_rf_read_addr = r_idx;
   assign o_unlocked     = (r_unlock_tmr != '0);

`ifdef LOCK_CTRL_LOCKOUT_EN
   localparam logic [2:0] c_ST_LOCKED = 3'd5;
   localparam int c_FW = $clog2(MAX_FAILS + 1);
   localparam int c_LW = $clog2(LOCKOUT_CYCLES + 1);

   logic [c_FW-1:0] r_fail_cnt;
   logic [c_LW-1:0] r_lock_tmr;
   logic            r_go_lock;
   logic [c_FW-1:0] w_fail_next;
   logic            w_lock_trip;

   assign w_fail_next = (r_fail_cnt == c_FW'(MAX_FAILS)) ? r_fail_cnt
                                                         : r_fail_cnt + c_FW'(1);
   assign w_lock_trip = w_verify_fail && (w_fail_next == c_FW'(MAX_FAILS));
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{32'(MAX_FAILS), 32'(LOCKOUT_CYCLES), w_verify_fail};
   assign o_alarm      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_unlock_tmr <= '0;
      end else if (w_verify_ok) begin
         r_unlock_tmr <= c_UW'(UNLOCK_CYCLES);
      end else if (r_unlock_tmr != '0) begin
         r_unlock_tmr <= r_unlock_tmr - c_UW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_code         <= '0;
         r_cmd          <= '0;
         r_auth         <= 1'b0;
         r_idx          <= '0;
         r_match        <= 1'b0;
         r_any_valid    <= 1'b0;
         r_free_vld     <= 1'b0;
         r_free_addr    <= '0;
         o_rf_data_in   <= '0;
         o_rf_save      <= 1'b0;
         o_rf_save_addr <= '0;
         o_rf_delete    <= 1'b0;
         o_rf_del_addr  <= '0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_status       <= '0;
`ifdef LOCK_CTRL_LOCKOUT_EN
         r_fail_cnt     <= '0;
         r_lock_tmr     <= '0;
         r_go_lock      <= 1'b0;
         o_alarm        <= 1'b0;
`endif
      end else begin
         o_rf_save   <= 1'b0;
         o_rf_delete <= 1'b0;
         o_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_code_valid && (i_cmd != c_CMD_RSVD)) begin
                  r_code <= i_code_in;
                  r_cmd  <= i_cmd;
                  r_auth <= o_unlocked;
                  o_busy <= 1'b1;
                  if (i_cmd == c_CMD_DELETE) begin
                     if (!o_unlocked) begin
                        r_state  <= S_DONE;
                        o_done   <= 1'b1;
                        o_status <= c_ST_AUTH;
                     end else begin
                        r_state       <= S_DEL;
                        o_rf_delete   <= 1'b1;
                        o_rf_del_addr <= i_slot_sel;
                     end
                  end else begin
                     r_state     <= S_SCAN;
                     r_idx       <= '0;
                     r_match     <= 1'b0;
                     r_any_valid <= 1'b0;
                     r_free_vld  <= 1'b0;
                     r_free_addr <= '0;
                  end
               end
            end
            S_SCAN: begin
               r_match     <= w_match;
               r_any_valid <= w_any_valid;
               r_free_vld  <= w_free_vld;
               r_free_addr <= w_free_addr;
               r_idx       <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  if (r_cmd == c_CMD_VERIFY) begin
                     r_state  <= S_DONE;
                     o_done   <= 1'b1;
                     o_status <= w_match ? c_ST_OK : c_ST_NOMATCH;
`ifdef LOCK_CTRL_LOCKOUT_EN
                     if (w_match) begin
                        r_fail_cnt <= '0;
                     end else begin
                        r_fail_cnt <= w_fail_next;
                        r_go_lock  <= w_lock_trip;
                     end
`endif
                  end else if (!r_auth && w_any_valid) begin
                     r_state  <= S_DONE;
                     o_done   <= 1'b1;
                     o_status <= c_ST_AUTH;
                  end else if (w_match) begin
                     r_state  <= S_DONE;
                     o_done   <= 1'b1;
                     o_status <= c_ST_DUP;
                  end else if (!w_free_vld) begin
                     r_state  <= S_DONE;
                     o_done   <= 1'b1;
                     o_status <= c_ST_FULL;
                  end else begin
                     r_state        <= S_SAVE;
                     o_rf_save      <= 1'b1;
                     o_rf_save_addr <= w_free_addr;
                     o_rf_data_in   <= r_code;
                  end
               end
            end
            S_SAVE, S_DEL: begin
               r_state  <= S_DONE;
               o_done   <= 1'b1;
               o_status <= c_ST_OK;
            end
            S_DONE: begin
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
`ifdef LOCK_CTRL_LOCKOUT_EN
               if (r_go_lock) begin
                  r_state    <= S_LOCKOUT;
                  r_go_lock  <= 1'b0;
                  o_alarm    <= 1'b1;
                  r_lock_tmr <= c_LW'(LOCKOUT_CYCLES);
               end
`endif
            end
`ifdef LOCK_CTRL_LOCKOUT_EN
            S_LOCKOUT: begin
               if (i_code_valid) begin
                  o_done   <= 1'b1;
                  o_status <= c_ST_LOCKED;
               end
               if (r_lock_tmr <= c_LW'(1)) begin
                  r_state    <= S_IDLE;
                  o_alarm    <= 1'b0;
                  r_fail_cnt <= '0;
               end else begin
                  r_lock_tmr <= r_lock_tmr - c_LW'(1);
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_ctrl
// Purpose  : Directed self-checking bench for lock_ctrl with a behavioural
//            4-slot register file model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lock_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] code_in = '0;
   logic        code_valid = 1'b0;
   logic [1:0]  cmd = '0;
   logic [1:0]  slot_sel = '0;
   logic [16:0] rf_data_out;
   logic [15:0] rf_data_in;
   logic        rf_save;
   logic [1:0]  rf_save_addr;
   logic        rf_delete;
   logic [1:0]  rf_del_addr;
   logic [1:0]  rf_read_addr;
   logic        busy;
   logic        done;
   logic [2:0]  status;
   logic        unlocked;
   logic        alarm;

   int n_vec = 0;
   int n_err = 0;

   int          done_at, save_at, del_at;
   logic [2:0]  st;
   logic [1:0]  save_addr, del_addr;
   logic [15:0] save_data;
   logic        unl_at_done, busy_t1;

   logic [16:0] rf [0:3] = '{17'h0, 17'h0, 17'h0, 17'h0};

   always #5 clk = ~clk;

   lock_ctrl #(
      .UNLOCK_CYCLES  (8),
      .MAX_FAILS      (3),
      .LOCKOUT_CYCLES (10)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_code_in      (code_in),
      .i_code_valid   (code_valid),
      .i_cmd          (cmd),
      .i_slot_sel     (slot_sel),
      .i_rf_data_out  (rf_data_out),
      .o_rf_data_in   (rf_data_in),
      .o_rf_save      (rf_save),
      .o_rf_save_addr (rf_save_addr),
      .o_rf_delete    (rf_delete),
      .o_rf_del_addr  (rf_del_addr),
      .o_rf_read_addr (rf_read_addr),
      .o_busy         (busy),
      .o_done         (done),
      .o_status       (status),
      .o_unlocked     (unlocked),
      .o_alarm        (alarm)
   );

   assign rf_data_out = rf[rf_read_addr];

   always @(posedge clk) begin
      if (rf_save)   rf[rf_save_addr] <= {1'b1, rf_data_in};
      if (rf_delete) rf[rf_del_addr]  <= 17'h0;
   end

   // Issue one command and record event offsets relative to accept cycle T.
   task automatic run_cmd(input logic [1:0] c, input logic [15:0] code, input logic [1:0] slot);
      @(negedge clk);
      code_valid = 1'b1; cmd = c; code_in = code; slot_sel = slot;
      @(negedge clk);
      code_valid = 1'b0;
      done_at = 0; save_at = 0; del_at = 0; st = 3'd7;
      save_addr = '0; del_addr = '0; save_data = '0; unl_at_done = 1'b0;
      busy_t1 = busy;
      for (int k = 1; k <= 12 && done_at == 0; k++) begin
         if (k > 1) @(negedge clk);
         if (rf_save && save_at == 0) begin
            save_at = k; save_addr = rf_save_addr; save_data = rf_data_in;
         end
         if (rf_delete && del_at == 0) begin
            del_at = k; del_addr = rf_del_addr;
         end
         if (done) begin
            done_at = k; st = status; unl_at_done = unlocked;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy, done, status, unlocked, alarm, rf_save, rf_delete, rf_read_addr} !== 12'h0) begin
         n_err++; $display("FAIL reset_held: got %0h expected 0",
            {busy, done, status, unlocked, alarm, rf_save, rf_delete, rf_read_addr});
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({busy, done, status, unlocked, alarm, rf_save, rf_delete} !== 10'h0) begin
         n_err++; $display("FAIL reset_released: got %0h expected 0",
            {busy, done, status, unlocked, alarm, rf_save, rf_delete});
      end
   endtask

   task automatic test_enroll_first;
      run_cmd(2'd1, 16'h1234, 2'd0);
      n_vec++;
      if (busy_t1 !== 1'b1) begin n_err++; $display("FAIL enroll1_busy: got %0b expected 1", busy_t1); end
      n_vec++;
      if (save_at !== 5) begin n_err++; $display("FAIL enroll1_save_at: got %0d expected 5", save_at); end
      n_vec++;
      if ({save_addr, save_data} !== {2'd0, 16'h1234}) begin
         n_err++; $display("FAIL enroll1_save_word: got %0h expected %0h", {save_addr, save_data}, {2'd0, 16'h1234});
      end
      n_vec++;
      if (done_at !== 6 || st !== 3'd0) begin
         n_err++; $display("FAIL enroll1_done: got at %0d st %0d expected at 6 st 0", done_at, st);
      end
   endtask

   task automatic test_verify_ok;
      int cnt;
      run_cmd(2'd0, 16'h1234, 2'd0);
      n_vec++;
      if (done_at !== 5 || st !== 3'd0 || unl_at_done !== 1'b1) begin
         n_err++; $display("FAIL verify_ok: got at %0d st %0d unl %0b expected at 5 st 0 unl 1", done_at, st, unl_at_done);
      end
      cnt = unlocked ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!unlocked) break;
         cnt++;
      end
      n_vec++;
      if (cnt !== 8) begin n_err++; $display("FAIL unlock_len: got %0d expected 8", cnt); end
   endtask

   task automatic test_enroll_dup;
      run_cmd(2'd0, 16'h1234, 2'd0);
      run_cmd(2'd1, 16'h1234, 2'd0);
      n_vec++;
      if (done_at !== 5 || st !== 3'd3 || save_at !== 0) begin
         n_err++; $display("FAIL enroll_dup: got at %0d st %0d save %0d expected at 5 st 3 save 0", done_at, st, save_at);
      end
   endtask

   task automatic test_enroll_fill;
      logic [15:0] codes [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      for (int i = 0; i < 3; i++) begin
         run_cmd(2'd0, 16'h1234, 2'd0);
         run_cmd(2'd1, codes[i], 2'd0);
         n_vec++;
         if (save_at !== 5 || save_addr !== 2'(i + 1) || save_data !== codes[i] || done_at !== 6 || st !== 3'd0) begin
            n_err++; $display("FAIL enroll_fill%0d: got save %0d addr %0d data %0h done %0d st %0d expected save 5 addr %0d data %0h done 6 st 0",
               i, save_at, save_addr, save_data, done_at, st, i + 1, codes[i]);
         end
      end
      run_cmd(2'd0, 16'h1234, 2'd0);
      run_cmd(2'd1, 16'hDDDD, 2'd0);
      n_vec++;
      if (done_at !== 5 || st !== 3'd2 || save_at !== 0) begin
         n_err++; $display("FAIL enroll_full: got at %0d st %0d save %0d expected at 5 st 2 save 0", done_at, st, save_at);
      end
   endtask

   task automatic test_delete;
      for (int k = 0; k < 40; k++) begin
         if (!unlocked) break;
         @(negedge clk);
      end
      n_vec++;
      if (unlocked !== 1'b0) begin n_err++; $display("FAIL relock: got %0b expected 0", unlocked); end
      run_cmd(2'd2, 16'h0000, 2'd1);
      n_vec++;
      if (done_at !== 1 || st !== 3'd4 || del_at !== 0) begin
         n_err++; $display("FAIL delete_auth: got at %0d st %0d del %0d expected at 1 st 4 del 0", done_at, st, del_at);
      end
      run_cmd(2'd0, 16'h1234, 2'd0);
      run_cmd(2'd2, 16'h0000, 2'd1);
      n_vec++;
      if (del_at !== 1 || del_addr !== 2'd1 || done_at !== 2 || st !== 3'd0) begin
         n_err++; $display("FAIL delete_ok: got del %0d addr %0d done %0d st %0d expected del 1 addr 1 done 2 st 0",
            del_at, del_addr, done_at, st);
      end
      run_cmd(2'd0, 16'hAAAA, 2'd0);
      n_vec++;
      if (done_at !== 5 || st !== 3'd1) begin
         n_err++; $display("FAIL verify_deleted: got at %0d st %0d expected at 5 st 1", done_at, st);
      end
   endtask

   task automatic test_lockout;
      int cnt;
      run_cmd(2'd0, 16'h1234, 2'd0);
      for (int i = 0; i < 3; i++) begin
         run_cmd(2'd0, 16'h0000, 2'd0);
         n_vec++;
         if (done_at !== 5 || st !== 3'd1) begin
            n_err++; $display("FAIL wrong_verify%0d: got at %0d st %0d expected at 5 st 1", i, done_at, st);
         end
      end
      @(negedge clk);
`ifdef LOCK_CTRL_LOCKOUT_EN
      n_vec++;
      if (alarm !== 1'b1) begin n_err++; $display("FAIL alarm_rise: got %0b expected 1", alarm); end
      cnt = alarm ? 1 : 0;
      code_valid = 1'b1; cmd = 2'd0; code_in = 16'h1234;
      @(negedge clk);
      code_valid = 1'b0;
      if (alarm) cnt++;
      @(negedge clk);
      if (alarm) cnt++;
      n_vec++;
      if (done !== 1'b1 || status !== 3'd5 || busy !== 1'b0) begin
         n_err++; $display("FAIL lockout_cmd: got done %0b st %0d busy %0b expected done 1 st 5 busy 0", done, status, busy);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!alarm) break;
         cnt++;
      end
      n_vec++;
      if (cnt !== 10) begin n_err++; $display("FAIL alarm_len: got %0d expected 10", cnt); end
`else
      n_vec++;
      if (alarm !== 1'b0) begin n_err++; $display("FAIL alarm_disabled: got %0b expected 0", alarm); end
      run_cmd(2'd0, 16'h0000, 2'd0);
      n_vec++;
      if (done_at !== 5 || st !== 3'd1 || alarm !== 1'b0) begin
         n_err++; $display("FAIL no_lockout: got at %0d st %0d alarm %0b expected at 5 st 1 alarm 0", done_at, st, alarm);
      end
`endif
   endtask

   task automatic test_reset_mid;
      run_cmd(2'd0, 16'h1234, 2'd0);
      @(negedge clk);
      code_valid = 1'b1; cmd = 2'd0; code_in = 16'h1234;
      @(negedge clk);
      code_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1 || unlocked !== 1'b1) begin
         n_err++; $display("FAIL pre_reset: got busy %0b unl %0b expected 1 1", busy, unlocked);
      end
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, done, rf_save, rf_delete, unlocked, alarm} !== 6'h0) begin
         n_err++; $display("FAIL async_reset: got %0h expected 0", {busy, done, rf_save, rf_delete, unlocked, alarm});
      end
      @(negedge clk);
      reset_n = 1'b1;
      run_cmd(2'd0, 16'h1234, 2'd0);
      n_vec++;
      if (done_at !== 5 || st !== 3'd0 || unl_at_done !== 1'b1) begin
         n_err++; $display("FAIL post_reset_verify: got at %0d st %0d unl %0b expected at 5 st 0 unl 1", done_at, st, unl_at_done);
      end
   endtask

   initial begin
      test_reset;
      test_enroll_first;
      test_verify_ok;
      test_enroll_dup;
      test_enroll_fill;
      test_delete;
      test_lockout;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
